// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued long-latency results,
// with head-age starvation freeze and a per-register pending scoreboard for decode.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_dst,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_dst,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0]    AGE_LIMIT  = 4'(MAX_WAIT);

    logic [4:0]    fifoDst  [DEPTH];
    logic [31:0]   fifoData [DEPTH];
    logic [PW-1:0] rdPtrReg;
    logic [PW-1:0] wrPtrReg;
    logic [CW-1:0] countReg;
    logic [3:0]    ageReg;
    logic [3:0]    ageNext;
    logic [31:0]   pendingReg;
    logic [31:0]   pendingNext;

    logic        notEmpty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        grantWb;
    logic        stallInt;
    logic [4:0]  headDst;
    logic [31:0] headData;

    assign notEmpty = (countReg != '0);
    assign headDst  = fifoDst[rdPtrReg];
    assign headData = fifoData[rdPtrReg];

    // No look-ahead to a same-cycle pop: a full FIFO refuses even if it drains now.
    assign lu_ready = !reset && (countReg < FULL_COUNT);
    assign accept   = lu_valid && lu_ready;
    assign push     = accept && (lu_dst != 5'd0);

    assign stallInt = !reset && notEmpty && (ageReg == AGE_LIMIT);
    assign wb_stall = stallInt;

    always_comb begin
        grantWb = 1'b0;
        pop     = 1'b0;
        if (!reset) begin
            if (stallInt) begin
                pop = 1'b1;
            end else if (wb_we && (wb_dst != 5'd0)) begin
                grantWb = 1'b1;
            end else if (notEmpty) begin
                pop = 1'b1;
            end
        end
    end

    assign rf_we    = grantWb || pop;
    assign rf_addr  = pop ? headDst  : wb_dst;
    assign rf_wdata = pop ? headData : wb_data;

    // Age tracks only the current head; a pop hands a fresh head a zero age.
    always_comb begin
        ageNext = ageReg;
        if (!notEmpty || pop) begin
            ageNext = 4'd0;
        end else if (ageReg != AGE_LIMIT) begin
            ageNext = ageReg + 4'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pendingNext[gi] = 1'b0;
            end else begin : g_reg
                logic setBit;
                logic clrBit;
                assign setBit = iss_valid && (iss_dst == 5'(gi));
                assign clrBit = pop && (headDst == 5'(gi));
                // A same-cycle issue to the register being retired keeps it pending.
                assign pendingNext[gi] = setBit || (pendingReg[gi] && !clrBit);
            end
        end
    endgenerate

    // The register written by this cycle's pop is no longer a hazard for decode.
    assign rs_busy = !reset && pendingReg[q_rs] && !(pop && (headDst == q_rs));
    assign rt_busy = !reset && pendingReg[q_rt] && !(pop && (headDst == q_rt));

    always_ff @(posedge clk) begin
        if (reset) begin
            countReg   <= '0;
            rdPtrReg   <= '0;
            wrPtrReg   <= '0;
            ageReg     <= 4'd0;
            pendingReg <= '0;
        end else begin
            if (push) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            case ({push, pop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
            ageReg     <= ageNext;
            pendingReg <= pendingNext;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoDst[wrPtrReg]  <= lu_dst;
            fifoData[wrPtrReg] <= lu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes go into a scoreboard
// queue as stimulus is driven; a negedge monitor pops and compares every write.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_dst = '0;
    logic [31:0] wb_data = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_dst = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_dst = '0;
    logic [4:0]  q_rs = '0;
    logic [4:0]  q_rt = '0;
    logic        rs_busy;
    logic        rt_busy;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  compared   = 0;
    int  mismatched = 0;

    localparam logic [31:0] WBD = 32'h3333_3333;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_dst(lu_dst), .lu_data(lu_data), .lu_ready(lu_ready),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .q_rs(q_rs), .q_rt(q_rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Monitor: exactly the queued write (or none) must appear in every cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_addr, rf_wdata);
            end else begin
                e = expQ.pop_front();
                if (rf_addr !== e.addr || rf_wdata !== e.data) begin
                    mismatched++;
                    $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_addr, rf_wdata, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%h ok", rf_addr, rf_wdata);
                end
            end
        end else if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            e = expQ.pop_front();
            $display("FAIL missing_write: got rf_we=0, required addr=%0d data=%h", e.addr, e.data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        wb_we = 1'b0; wb_dst = '0; wb_data = '0;
        lu_valid = 1'b0; lu_dst = '0; lu_data = '0;
        iss_valid = 1'b0; iss_dst = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic expWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic wb3();
        wb_we = 1'b1; wb_dst = 5'd3; wb_data = WBD;
        expWrite(5'd3, WBD);
    endtask

    task automatic offer(input logic [4:0] d, input logic [31:0] v);
        lu_valid = 1'b1; lu_dst = d; lu_data = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        // Reset: outputs forced quiet even with a WB request present.
        cyc(); wb_we = 1'b1; wb_dst = 5'd3; wb_data = 32'h1; settle();
        chk("reset_rf_we", 32'(rf_we), 0);
        chk("reset_lu_ready", 32'(lu_ready), 0);
        chk("reset_wb_stall", 32'(wb_stall), 0);
        chk("reset_rs_busy", 32'(rs_busy), 0);
        cyc(); reset = 1'b0; settle();
        chk("post_reset_lu_ready", 32'(lu_ready), 1);

        // Idle drain.
        cyc(); iss_valid = 1'b1; iss_dst = 5'd5; q_rs = 5'd5; settle();
        chk("issue_same_cycle_busy", 32'(rs_busy), 0);
        cyc(); settle();
        chk("pending_set", 32'(rs_busy), 1);
        cyc(); offer(5'd5, 32'hDEAD_BEEF); settle();
        chk("drain_lu_ready", 32'(lu_ready), 1);
        chk("no_same_cycle_write", 32'(rf_we), 0);
        chk("busy_before_pop", 32'(rs_busy), 1);
        cyc(); expWrite(5'd5, 32'hDEAD_BEEF); settle();
        chk("busy_during_pop", 32'(rs_busy), 0);
        cyc(); settle();
        chk("busy_after_pop", 32'(rs_busy), 0);

        // WB priority and starvation.
        cyc(); wb3(); offer(5'd7, 32'h7777_7777); settle();
        chk("starve_stall_accept", 32'(wb_stall), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); wb3(); settle();
            chk("starve_stall_early", 32'(wb_stall), 0);
        end
        cyc(); wb_we = 1'b1; wb_dst = 5'd3; wb_data = WBD; expWrite(5'd7, 32'h7777_7777); settle();
        chk("starve_stall_raised", 32'(wb_stall), 1);
        cyc(); wb3(); settle();
        chk("starve_stall_dropped", 32'(wb_stall), 0);

        // Full FIFO under continuous WB traffic.
        cyc(); wb3(); offer(5'd9, 32'h9999_9999); settle();
        chk("full_ready_1", 32'(lu_ready), 1);
        cyc(); wb3(); offer(5'd10, 32'hAAAA_AAAA); settle();
        chk("full_ready_2", 32'(lu_ready), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); wb3(); offer(5'd11, 32'hBBBB_BBBB); settle();
            chk("full_not_ready", 32'(lu_ready), 0);
            chk("full_stall_low", 32'(wb_stall), 0);
        end
        cyc(); wb_we = 1'b1; wb_dst = 5'd3; wb_data = WBD; offer(5'd11, 32'hBBBB_BBBB);
        expWrite(5'd9, 32'h9999_9999); settle();
        chk("full_stall_raised", 32'(wb_stall), 1);
        chk("full_no_lookahead", 32'(lu_ready), 0);
        cyc(); wb3(); offer(5'd11, 32'hBBBB_BBBB); settle();
        chk("full_ready_after_pop", 32'(lu_ready), 1);
        chk("full_stall_cleared", 32'(wb_stall), 0);
        cyc(); expWrite(5'd10, 32'hAAAA_AAAA); settle();
        chk("full_again_not_ready", 32'(lu_ready), 0);
        cyc(); offer(5'd12, 32'hCCCC_CCCC); expWrite(5'd11, 32'hBBBB_BBBB); settle();
        chk("push_pop_ready", 32'(lu_ready), 1);
        cyc(); expWrite(5'd12, 32'hCCCC_CCCC); settle();
        cyc(); settle();
        chk("drained_empty", 32'(rf_we), 0);

        // $0 handling.
        cyc(); offer(5'd0, 32'h1234_5678); settle();
        chk("zero_accept_ready", 32'(lu_ready), 1);
        cyc(); wb_we = 1'b1; wb_dst = 5'd0; wb_data = 32'hFFFF_FFFF; settle();
        chk("wb_zero_no_we", 32'(rf_we), 0);
        cyc(); iss_valid = 1'b1; iss_dst = 5'd0; q_rs = 5'd0; settle();
        cyc(); settle();
        chk("zero_never_busy", 32'(rs_busy), 0);

        // Set/clear collision.
        cyc(); iss_valid = 1'b1; iss_dst = 5'd4; q_rs = 5'd4;
        cyc(); offer(5'd4, 32'h4444_4444); settle();
        chk("collision_busy_before", 32'(rs_busy), 1);
        cyc(); iss_valid = 1'b1; iss_dst = 5'd4; expWrite(5'd4, 32'h4444_4444); settle();
        chk("collision_busy_during_pop", 32'(rs_busy), 0);
        cyc(); settle();
        chk("collision_set_wins", 32'(rs_busy), 1);

        // Reset mid-operation with two queued entries.
        cyc(); wb3(); iss_valid = 1'b1; iss_dst = 5'd6; offer(5'd6, 32'h6666_6666);
        cyc(); wb3(); offer(5'd8, 32'h8888_8888); q_rs = 5'd6; q_rt = 5'd4; settle();
        chk("pre_reset_rs_busy", 32'(rs_busy), 1);
        chk("pre_reset_rt_busy", 32'(rt_busy), 1);
        cyc(); reset = 1'b1; wb_we = 1'b1; wb_dst = 5'd3; wb_data = WBD; settle();
        chk("in_reset_rf_we", 32'(rf_we), 0);
        chk("in_reset_lu_ready", 32'(lu_ready), 0);
        chk("in_reset_rs_busy", 32'(rs_busy), 0);
        chk("in_reset_rt_busy", 32'(rt_busy), 0);
        cyc(); reset = 1'b0; settle();
        chk("after_reset_lu_ready", 32'(lu_ready), 1);
        chk("after_reset_rf_we", 32'(rf_we), 0);
        chk("after_reset_rs_busy", 32'(rs_busy), 0);
        chk("after_reset_rt_busy", 32'(rt_busy), 0);
        chk("after_reset_wb_stall", 32'(wb_stall), 0);
        cyc(); settle();
        chk("no_stale_drain", 32'(rf_we), 0);

        cyc(); settle();
        chk("scoreboard_empty", 32'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
